s_spi_regbank: RTL and testbench
================================

Name: s_spi_regbank

Overview:
- SPI slave responder with an integrated register table; the far end of m_spi's 4-line bus.
- Decodes write/read frames from the master and commits writes to the table. On reads it returns table contents on miso.
- A local user-side port lets on-chip logic read and update the same table.
- All SPI pins are oversampled in user_clk; no sclk-domain logic.

Parameters:
USER_CLK_RATE, 32'd100_000_000, user_clk frequency in Hz; must be >= 8*SPI_CLK_RATE
SPI_CLK_RATE, 32'd2_500_000, nominal sclk frequency in Hz
MCS_VALID_LEVEL, 1'b0, active level of mcs
SCK_MODE, 2'b01, {CPOL,CPHA}
AWIDTH, 16'd15, address field width
DWIDTH, 16'd8, data field width
REG_DEPTH, 16'd256, number of implemented registers (addresses 0..REG_DEPTH-1)

Ports:
user_clk  in  1  user clock
user_rst_n  in  1  reset; one clock; reset is synchronous and active-low
mcs  in  1  SPI chip select
sclk  in  1  SPI clock
mosi  in  1  SPI master-out
miso  out  1  SPI slave-out; 0 when not selected
o_wr_evt  out  1  1-cycle pulse: SPI write committed
o_rd_evt  out  1  1-cycle pulse: SPI read data loaded for shifting
o_addr  out  AWIDTH  address of last decoded frame
o_wr_data  out  DWIDTH  data of last SPI write
o_abort_evt  out  1  1-cycle pulse: frame ended early
o_oor_evt  out  1  1-cycle pulse: frame addressed >= REG_DEPTH
i_loc_wr_evt  in  1  local write strobe
i_loc_addr  in  AWIDTH  local address
i_loc_wr_data  in  DWIDTH  local write data
o_loc_rd_data  out  DWIDTH  table[i_loc_addr], registered, 1-cycle latency

Behaviour:
- Reset (user_rst_n=0 at a user_clk edge):
  - All outputs 0; FSM to IDLE; shift registers and bit counter cleared.
  - Register table cleared to 0.
  - Reset mid-frame aborts the frame silently: no o_abort_evt, no write.
- Input synchronisation:
  - mcs, sclk and mosi pass through 2-flop synchronisers, then a 1-flop edge detector.
  - Decode latency from pin to internal edge strobe: 3 user_clk.
- Edge mapping:
  - Sample edge (mosi captured) = leading edge when CPHA=0, trailing edge when CPHA=1.
  - Drive edge (miso updated) = the other edge.
  - Leading edge = rising when CPOL=0, falling when CPOL=1.
- Frame format, MSB first:
  - Bit 0: R/W (1=read).
  - Next AWIDTH bits: address.
  - Next DWIDTH bits: data.
  - Total 1+AWIDTH+DWIDTH sample edges (24 at defaults).
- FSM:
  - IDLE: wait for mcs == MCS_VALID_LEVEL → HDR; bit counter = 0.
  - HDR: shift 1+AWIDTH bits on sample edges.
    - After the last one: latch o_addr.
    - Read → RDATA: load shift register with table[addr] (0 if out of range) and pulse o_rd_evt in the same cycle.
    - Write → WDATA.
  - RDATA: the MSB is driven on the first drive edge after the last header sample; the next bit on each later drive edge. After DWIDTH sample edges → DONE.
  - WDATA: shift DWIDTH bits. On the cycle after the last sample-edge strobe:
    - if addr < REG_DEPTH: write the table, update o_wr_data, pulse o_wr_evt;
    - → DONE.
  - DONE: ignore further sclk edges; mcs deassert → IDLE.
- Early termination: mcs deasserted in HDR, WDATA or RDATA → pulse o_abort_evt, no table write, → IDLE.
- Out-of-range address (addr >= REG_DEPTH):
  - o_oor_evt pulses at header completion.
  - Write is dropped; read returns all zeros.
  - Frame still runs to completion.
- miso:
  - 0 in IDLE, HDR and DONE.
  - In RDATA, holds the current shift MSB.
  - Forced 0 combinationally when synchronised mcs is inactive.
- Local port:
  - o_loc_rd_data <= table[i_loc_addr] every cycle; 0 for out-of-range addresses.
  - i_loc_wr_evt with in-range address writes the table.
  - Same-cycle SPI commit and local write to the same address: SPI wins, local write is dropped. Different addresses: both are written.
  - A local write landing after the RDATA load does not alter the data being shifted.
- Width rules: address compare is unsigned, AWIDTH bits. No address wrap-around.

Test Plan:
- Mode 01, defaults: SPI write addr 1 data 0x55, then SPI read addr 1 → o_wr_evt once with o_addr=1, o_wr_data=0x55; read frame returns 0x55 on miso, o_rd_evt once; o_loc_rd_data=0x55 with i_loc_addr=1.
- Repeat the write/read pair in SCK_MODE 00, 10 and 11 with random data → read-back matches every time; no abort or oor pulses.
- Write addr 300 data 0xA5, then read addr 300 → o_oor_evt on both frames; no o_wr_evt; miso data field all zeros; table unchanged.
- Write frame to addr 2 with mcs deasserted after 10 sclk cycles → o_abort_evt one pulse; table[2] keeps its prior value; the next full frame decodes correctly.
- Local write addr 3=0x11 in the same cycle as an SPI commit addr 3=0x22 → table[3]=0x22. Then local write addr 3=0x33 during an SPI read of addr 3 after the load → miso returns 0x22 and table[3]=0x33.
- user_rst_n low for 1 cycle mid-WDATA → all outputs 0, table cleared, no write; the next frame works normally.

Source files
------------

// File: rtl/s_spi_regbank_if.sv
// SPI pin bundle between the 4-line master and the register-bank responder.
// Combinational wires only; SPI has no backpressure, so there is no flow control on these pins.
interface s_spi_regbank_if;
  logic mcs;
  logic sclk;
  logic mosi;
  logic miso;

  modport master (output mcs, output sclk, output mosi, input miso);
  modport slave  (input mcs, input sclk, input mosi, output miso);
endinterface

// File: rtl/s_spi_regbank.sv
// SPI slave register bank, all pins oversampled in user_clk; 3-clk pin-to-strobe, local read 1 clk.
// No backpressure: SPI frames are accepted at line rate and a same-address local write loses to an SPI commit.
module s_spi_regbank #(
  parameter logic [31:0] USER_CLK_RATE   = 32'd100_000_000,
  parameter logic [31:0] SPI_CLK_RATE    = 32'd2_500_000,
  parameter logic        MCS_VALID_LEVEL = 1'b0,
  parameter logic [1:0]  SCK_MODE        = 2'b01,
  parameter logic [15:0] AWIDTH          = 16'd15,
  parameter logic [15:0] DWIDTH          = 16'd8,
  parameter logic [15:0] REG_DEPTH       = 16'd256
) (
  input  logic              user_clk,
  input  logic              user_rst_n,
  s_spi_regbank_if.slave    spi,
  output logic              o_wr_evt,
  output logic              o_rd_evt,
  output logic [AWIDTH-1:0] o_addr,
  output logic [DWIDTH-1:0] o_wr_data,
  output logic              o_abort_evt,
  output logic              o_oor_evt,
  input  logic              i_loc_wr_evt,
  input  logic [AWIDTH-1:0] i_loc_addr,
  input  logic [DWIDTH-1:0] i_loc_wr_data,
  output logic [DWIDTH-1:0] o_loc_rd_data
);

  localparam int LP_IW = (REG_DEPTH > 16'd1) ? $clog2(REG_DEPTH) : 1;
  localparam int LP_CW = $clog2(((AWIDTH > DWIDTH) ? AWIDTH : DWIDTH) + 16'd1) + 1;
  localparam logic [LP_CW-1:0] LP_HDR_LAST = LP_CW'(AWIDTH);
  localparam logic [LP_CW-1:0] LP_DAT_LAST = LP_CW'(DWIDTH - 16'd1);

  if (USER_CLK_RATE < 32'd8 * SPI_CLK_RATE) begin : g_rate_chk
    $error("USER_CLK_RATE must be at least 8x SPI_CLK_RATE");
  end

  typedef enum logic [2:0] {
    ST_IDLE, ST_HDR, ST_WDATA, ST_WCMT, ST_RDATA, ST_DONE
  } state_t;

  state_t            r_state;
  logic [1:0]        r_mcs_s, r_sclk_s, r_mosi_s;
  logic              r_sclk_d;
  logic              r_armed;
  logic              r_miso;
  logic              r_addr_ok;
  logic [LP_CW-1:0]  r_cnt;
  logic [AWIDTH-1:0] r_hdr;
  logic [DWIDTH-1:0] r_wsh;
  logic [DWIDTH-1:0] r_rsh;
  logic [DWIDTH-1:0] r_tbl [REG_DEPTH];

  logic              w_mcs_act, w_rise, w_fall, w_lead, w_trail, w_sample, w_drive, w_mosi;
  logic [AWIDTH:0]   w_hdr_next;
  logic [AWIDTH-1:0] w_hdr_addr;
  logic              w_hdr_ok;
  logic [DWIDTH-1:0] w_hdr_rdat;
  logic              w_spi_cmt, w_loc_ok;

  function automatic logic f_in_range(input logic [AWIDTH-1:0] a);
    return 32'(a) < 32'(REG_DEPTH);
  endfunction

  // Synchronisers free-run through reset so pin state is known the cycle reset lifts.
  always_ff @(posedge user_clk) begin
    r_mcs_s  <= {r_mcs_s[0], spi.mcs};
    r_sclk_s <= {r_sclk_s[0], spi.sclk};
    r_mosi_s <= {r_mosi_s[0], spi.mosi};
    r_sclk_d <= r_sclk_s[1];
  end

  assign w_mcs_act = (r_mcs_s[1] == MCS_VALID_LEVEL);
  assign w_rise    = r_sclk_s[1] & ~r_sclk_d;
  assign w_fall    = ~r_sclk_s[1] & r_sclk_d;
  assign w_lead    = SCK_MODE[1] ? w_fall : w_rise;
  assign w_trail   = SCK_MODE[1] ? w_rise : w_fall;
  assign w_sample  = SCK_MODE[0] ? w_trail : w_lead;
  assign w_drive   = SCK_MODE[0] ? w_lead : w_trail;
  assign w_mosi    = r_mosi_s[1];

  assign w_hdr_next = {r_hdr, w_mosi};
  assign w_hdr_addr = w_hdr_next[AWIDTH-1:0];
  assign w_hdr_ok   = f_in_range(w_hdr_addr);
  assign w_hdr_rdat = w_hdr_ok ? r_tbl[w_hdr_addr[LP_IW-1:0]] : '0;

  assign w_spi_cmt = (r_state == ST_WCMT) && r_addr_ok;
  assign w_loc_ok  = i_loc_wr_evt && f_in_range(i_loc_addr) &&
                     !(w_spi_cmt && (i_loc_addr == o_addr));

  assign spi.miso = r_miso & w_mcs_act;

  // r_armed blocks pickup of a frame already in flight when reset lifted.
  always_ff @(posedge user_clk) begin
    if (!user_rst_n) begin
      r_state     <= ST_IDLE;
      r_armed     <= 1'b0;
      r_miso      <= 1'b0;
      r_addr_ok   <= 1'b0;
      r_cnt       <= '0;
      r_hdr       <= '0;
      r_wsh       <= '0;
      r_rsh       <= '0;
      o_wr_evt    <= 1'b0;
      o_rd_evt    <= 1'b0;
      o_abort_evt <= 1'b0;
      o_oor_evt   <= 1'b0;
      o_addr      <= '0;
      o_wr_data   <= '0;
    end else begin
      o_wr_evt    <= 1'b0;
      o_rd_evt    <= 1'b0;
      o_abort_evt <= 1'b0;
      o_oor_evt   <= 1'b0;
      if (!w_mcs_act) r_armed <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          r_miso <= 1'b0;
          r_cnt  <= '0;
          if (w_mcs_act && r_armed) r_state <= ST_HDR;
        end
        ST_HDR: begin
          if (!w_mcs_act) begin
            o_abort_evt <= 1'b1;
            r_state     <= ST_IDLE;
          end else if (w_sample) begin
            r_hdr <= w_hdr_next[AWIDTH-1:0];
            if (r_cnt == LP_HDR_LAST) begin
              r_cnt     <= '0;
              o_addr    <= w_hdr_addr;
              r_addr_ok <= w_hdr_ok;
              o_oor_evt <= !w_hdr_ok;
              if (w_hdr_next[AWIDTH]) begin
                r_rsh    <= w_hdr_rdat;
                o_rd_evt <= 1'b1;
                r_state  <= ST_RDATA;
              end else begin
                r_state  <= ST_WDATA;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        ST_WDATA: begin
          if (!w_mcs_act) begin
            o_abort_evt <= 1'b1;
            r_state     <= ST_IDLE;
          end else if (w_sample) begin
            r_wsh <= {r_wsh[DWIDTH-2:0], w_mosi};
            if (r_cnt == LP_DAT_LAST) r_state <= ST_WCMT;
            else                      r_cnt   <= r_cnt + 1'b1;
          end
        end
        ST_WCMT: begin
          if (r_addr_ok) begin
            o_wr_data <= r_wsh;
            o_wr_evt  <= 1'b1;
          end
          r_state <= ST_DONE;
        end
        ST_RDATA: begin
          if (!w_mcs_act) begin
            o_abort_evt <= 1'b1;
            r_miso      <= 1'b0;
            r_state     <= ST_IDLE;
          end else begin
            if (w_drive) begin
              r_miso <= r_rsh[DWIDTH-1];
              r_rsh  <= {r_rsh[DWIDTH-2:0], 1'b0};
            end
            if (w_sample) begin
              if (r_cnt == LP_DAT_LAST) begin
                r_miso  <= 1'b0;
                r_state <= ST_DONE;
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end
          end
        end
        ST_DONE: begin
          r_miso <= 1'b0;
          if (!w_mcs_act) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge user_clk) begin
    if (!user_rst_n) begin
      for (int i = 0; i < int'(REG_DEPTH); i++) r_tbl[i] <= '0;
      o_loc_rd_data <= '0;
    end else begin
      if (w_spi_cmt) r_tbl[o_addr[LP_IW-1:0]] <= r_wsh;
      if (w_loc_ok)  r_tbl[i_loc_addr[LP_IW-1:0]] <= i_loc_wr_data;
      o_loc_rd_data <= f_in_range(i_loc_addr) ? r_tbl[i_loc_addr[LP_IW-1:0]] : '0;
    end
  end

endmodule

// File: tb/tb_s_spi_regbank.sv
// Directed bench: one responder per SCK_MODE, driven by a bit-level SPI master model.
`timescale 1ns/1ps
module tb_s_spi_regbank;
  localparam int HALF = 8;

  logic        user_clk = 1'b0;
  logic        user_rst_n;
  logic [3:0]  mcs_v, sclk_v;
  logic        mosi_v;
  logic [3:0]  miso_v, wr_evt_v, rd_evt_v, abort_v, oor_v;
  logic [14:0] addr_v [4];
  logic [7:0]  wr_data_v [4];
  logic [7:0]  loc_rd_v [4];
  logic        i_loc_wr_evt;
  logic [14:0] i_loc_addr;
  logic [7:0]  i_loc_wr_data;
  int          strike_kind;
  int          wr_cnt [4], rd_cnt [4], ab_cnt [4], oor_cnt [4];
  int          checks = 0, failures = 0;

  always #5 user_clk = ~user_clk;

  for (genvar g = 0; g < 4; g++) begin : gm
    s_spi_regbank_if spi();
    assign spi.mcs  = mcs_v[g];
    assign spi.sclk = sclk_v[g];
    assign spi.mosi = mosi_v;
    assign miso_v[g] = spi.miso;
    s_spi_regbank #(.SCK_MODE(2'(g))) u_dut (
      .user_clk(user_clk), .user_rst_n(user_rst_n), .spi(spi),
      .o_wr_evt(wr_evt_v[g]), .o_rd_evt(rd_evt_v[g]), .o_addr(addr_v[g]),
      .o_wr_data(wr_data_v[g]), .o_abort_evt(abort_v[g]), .o_oor_evt(oor_v[g]),
      .i_loc_wr_evt(i_loc_wr_evt), .i_loc_addr(i_loc_addr),
      .i_loc_wr_data(i_loc_wr_data), .o_loc_rd_data(loc_rd_v[g]));
  end

  initial begin
    for (int k = 0; k < 4; k++) begin
      wr_cnt[k] = 0; rd_cnt[k] = 0; ab_cnt[k] = 0; oor_cnt[k] = 0;
    end
  end

  always @(negedge user_clk) begin
    for (int k = 0; k < 4; k++) begin
      if (wr_evt_v[k]) wr_cnt[k]  = wr_cnt[k] + 1;
      if (rd_evt_v[k]) rd_cnt[k]  = rd_cnt[k] + 1;
      if (abort_v[k])  ab_cnt[k]  = ab_cnt[k] + 1;
      if (oor_v[k])    oor_cnt[k] = oor_cnt[k] + 1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: sim time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // The strike lands on the 4th user_clk edge after a sample edge: the cycle the DUT commits a write.
  task automatic half_wait(input bit strike);
    if (strike) begin
      repeat (3) @(negedge user_clk);
      if (strike_kind == 1) i_loc_wr_evt = 1'b1;
      else                  user_rst_n   = 1'b0;
      @(negedge user_clk);
      i_loc_wr_evt = 1'b0;
      user_rst_n   = 1'b1;
      repeat (HALF - 4) @(negedge user_clk);
    end else begin
      repeat (HALF) @(negedge user_clk);
    end
  endtask

  task automatic spi_frame(input int m, input logic rw, input logic [14:0] a,
                           input logic [7:0] d, input int nbits, input int sbit,
                           output logic [7:0] rd, output logic hdr_miso);
    logic [23:0] f;
    logic cpol, cpha, b;
    f = {rw, a, d};
    cpol = 1'(m >> 1);
    cpha = 1'(m);
    rd = '0;
    hdr_miso = 1'b0;
    mosi_v = 1'b0;
    mcs_v[m] = 1'b0;
    half_wait(1'b0);
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        mosi_v = f[23-i];
        half_wait(1'b0);
        sclk_v[m] = ~cpol;
        b = miso_v[m];
        half_wait(i == sbit);
        sclk_v[m] = cpol;
      end else begin
        sclk_v[m] = ~cpol;
        mosi_v = f[23-i];
        half_wait(1'b0);
        sclk_v[m] = cpol;
        b = miso_v[m];
        half_wait(i == sbit);
      end
      if (i >= 16) rd = {rd[6:0], b};
      else         hdr_miso = hdr_miso | b;
    end
    half_wait(1'b0);
    mcs_v[m] = 1'b1;
    half_wait(1'b0);
    half_wait(1'b0);
  endtask

  task automatic loc_check(input string name, input int m, input logic [14:0] a, input logic [7:0] exp);
    i_loc_addr = a;
    repeat (2) @(negedge user_clk);
    check(name, 32'(loc_rd_v[m]), 32'(exp));
  endtask

  typedef struct {
    int          mode;
    logic        rw;
    logic [14:0] addr;
    logic [7:0]  data;
    logic [7:0]  exp_rd;
    int          exp_wr;
    int          exp_oor;
    logic [7:0]  exp_wrd;
  } vec_t;

  vec_t vecs [12];

  initial begin
    logic [7:0] rd;
    logic hm;
    int w0, r0, a0, o0, m;

    vecs[0]  = '{1, 1'b0, 15'd1,      8'h55, 8'h00, 1, 0, 8'h55};
    vecs[1]  = '{1, 1'b1, 15'd1,      8'h00, 8'h55, 0, 0, 8'h55};
    vecs[2]  = '{0, 1'b0, 15'd5,      8'hC3, 8'h00, 1, 0, 8'hC3};
    vecs[3]  = '{0, 1'b1, 15'd5,      8'h00, 8'hC3, 0, 0, 8'hC3};
    vecs[4]  = '{2, 1'b0, 15'h7F,     8'h3C, 8'h00, 1, 0, 8'h3C};
    vecs[5]  = '{2, 1'b1, 15'h7F,     8'h00, 8'h3C, 0, 0, 8'h3C};
    vecs[6]  = '{3, 1'b0, 15'hFF,     8'h96, 8'h00, 1, 0, 8'h96};
    vecs[7]  = '{3, 1'b1, 15'hFF,     8'h00, 8'h96, 0, 0, 8'h96};
    vecs[8]  = '{1, 1'b0, 15'd300,    8'hA5, 8'h00, 0, 1, 8'h55};
    vecs[9]  = '{1, 1'b1, 15'd300,    8'h00, 8'h00, 0, 1, 8'h55};
    vecs[10] = '{1, 1'b0, 15'd256,    8'h12, 8'h00, 0, 1, 8'h55};
    vecs[11] = '{1, 1'b1, 15'h7FFF,   8'h00, 8'h00, 0, 1, 8'h55};

    mcs_v = 4'b1111;
    sclk_v = 4'b1100;
    mosi_v = 1'b0;
    i_loc_wr_evt = 1'b0;
    i_loc_addr = 15'd1;
    i_loc_wr_data = 8'h00;
    strike_kind = 0;
    user_rst_n = 1'b0;
    repeat (4) @(negedge user_clk);
    user_rst_n = 1'b1;
    repeat (3) @(negedge user_clk);

    check("rst_addr",    32'(addr_v[1]), 32'h0);
    check("rst_wr_data", 32'(wr_data_v[1]), 32'h0);
    check("rst_miso",    32'(miso_v[1]), 32'h0);
    check("rst_loc_rd",  32'(loc_rd_v[1]), 32'h0);
    check("rst_evts",    32'(wr_cnt[1] + rd_cnt[1] + ab_cnt[1] + oor_cnt[1]), 32'h0);

    for (int i = 0; i < 12; i++) begin
      m = vecs[i].mode;
      w0 = wr_cnt[m]; r0 = rd_cnt[m]; a0 = ab_cnt[m]; o0 = oor_cnt[m];
      spi_frame(m, vecs[i].rw, vecs[i].addr, vecs[i].data, 24, -1, rd, hm);
      check($sformatf("v%0d_miso_data", i), 32'(rd), 32'(vecs[i].exp_rd));
      check($sformatf("v%0d_miso_hdr", i),  32'(hm), 32'h0);
      check($sformatf("v%0d_wr_evt", i),    32'(wr_cnt[m] - w0), 32'(vecs[i].exp_wr));
      check($sformatf("v%0d_rd_evt", i),    32'(rd_cnt[m] - r0), 32'(vecs[i].rw));
      check($sformatf("v%0d_oor_evt", i),   32'(oor_cnt[m] - o0), 32'(vecs[i].exp_oor));
      check($sformatf("v%0d_abort", i),     32'(ab_cnt[m] - a0), 32'h0);
      check($sformatf("v%0d_addr", i),      32'(addr_v[m]), 32'(vecs[i].addr));
      check($sformatf("v%0d_wr_data", i),   32'(wr_data_v[m]), 32'(vecs[i].exp_wrd));
    end

    loc_check("loc_rd_1",      1, 15'd1,   8'h55);
    loc_check("loc_rd_300",    1, 15'd300, 8'h00);
    loc_check("loc_rd_44",     1, 15'd44,  8'h00);
    loc_check("loc_rd_0",      1, 15'd0,   8'h00);
    loc_check("loc_rd_m2_7f",  2, 15'h7F,  8'h3C);

    // Early termination of a write, then a clean read of the same register.
    spi_frame(1, 1'b0, 15'd2, 8'h77, 24, -1, rd, hm);
    w0 = wr_cnt[1]; a0 = ab_cnt[1];
    spi_frame(1, 1'b0, 15'd2, 8'h99, 10, -1, rd, hm);
    check("abort_evt",    32'(ab_cnt[1] - a0), 32'd1);
    check("abort_no_wr",  32'(wr_cnt[1] - w0), 32'd0);
    loc_check("abort_tbl2", 1, 15'd2, 8'h77);
    a0 = ab_cnt[1]; r0 = rd_cnt[1];
    spi_frame(1, 1'b1, 15'd2, 8'h00, 24, -1, rd, hm);
    check("post_abort_rd",    32'(rd), 32'h77);
    check("post_abort_rdevt", 32'(rd_cnt[1] - r0), 32'd1);
    check("post_abort_noab",  32'(ab_cnt[1] - a0), 32'd0);

    // Local write colliding with the SPI commit cycle.
    strike_kind = 1;
    i_loc_addr = 15'd3; i_loc_wr_data = 8'h11;
    w0 = wr_cnt[1];
    spi_frame(1, 1'b0, 15'd3, 8'h22, 24, 23, rd, hm);
    check("coll_wr_evt", 32'(wr_cnt[1] - w0), 32'd1);
    loc_check("coll_same_addr", 1, 15'd3, 8'h22);
    i_loc_addr = 15'd4; i_loc_wr_data = 8'h44;
    spi_frame(1, 1'b0, 15'd6, 8'h66, 24, 23, rd, hm);
    loc_check("coll_diff_loc", 1, 15'd4, 8'h44);
    loc_check("coll_diff_spi", 1, 15'd6, 8'h66);
    i_loc_addr = 15'd3; i_loc_wr_data = 8'h33;
    spi_frame(1, 1'b1, 15'd3, 8'h00, 24, 18, rd, hm);
    check("late_loc_miso", 32'(rd), 32'h22);
    loc_check("late_loc_tbl", 1, 15'd3, 8'h33);

    // Reset pulse in the middle of the write data field.
    strike_kind = 2;
    w0 = wr_cnt[1]; a0 = ab_cnt[1];
    spi_frame(1, 1'b0, 15'd7, 8'h5A, 24, 20, rd, hm);
    check("mid_rst_no_wr",    32'(wr_cnt[1] - w0), 32'd0);
    check("mid_rst_no_abort", 32'(ab_cnt[1] - a0), 32'd0);
    check("mid_rst_addr",     32'(addr_v[1]), 32'h0);
    check("mid_rst_wr_data",  32'(wr_data_v[1]), 32'h0);
    check("mid_rst_miso",     32'(miso_v[1]), 32'h0);
    loc_check("mid_rst_tbl1", 1, 15'd1, 8'h00);
    loc_check("mid_rst_tbl3", 1, 15'd3, 8'h00);
    strike_kind = 0;
    w0 = wr_cnt[1];
    spi_frame(1, 1'b0, 15'd7, 8'h5A, 24, -1, rd, hm);
    check("post_rst_wr_evt", 32'(wr_cnt[1] - w0), 32'd1);
    check("post_rst_addr",   32'(addr_v[1]), 32'd7);
    spi_frame(1, 1'b1, 15'd7, 8'h00, 24, -1, rd, hm);
    check("post_rst_rd", 32'(rd), 32'h5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
